k2_program_loader: RTL and testbench



---
 rtl/k2_loader_pkg.sv | 17 +
 rtl/k2_inst_ram.sv | 26 ++
 rtl/k2_program_loader.sv | 137 +++++++++++++
 tb/tb_k2_program_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/k2_loader_pkg.sv
// Shared types and default widths for the k2 program loader.
// Build option: K2_LOADER_CHECKSUM_EN adds the CHECK/ERROR checksum path.
package k2_loader_pkg;

  localparam int K2_INST_W = 10;
  localparam int K2_ADDR_W = 4;

  // CHECK and ERROR are only reachable when K2_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } k2_state_e;

endpackage

// File: rtl/k2_inst_ram.sv
// Instruction store: synchronous write port, asynchronous read port, no reset
// so a program survives a loader reset.
module k2_inst_ram #(
  parameter int instW = 10,
  parameter int addrW = 4,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [addrW-1:0] waddr,
  input  logic [instW-1:0] wdata,
  input  logic [addrW-1:0] raddr,
  output logic [instW-1:0] rdata
);

  logic [instW-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// Loads a program into the k2 instruction store over a valid/ready stream,
// holding the core in reset until loading completes. Option: K2_LOADER_CHECKSUM_EN.
module k2_program_loader
  import k2_loader_pkg::*;
#(
  parameter int instW = K2_INST_W,
  parameter int addrW = K2_ADDR_W,
  parameter int depth = 2 ** addrW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             ld_valid,
  input  logic [instW-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic [addrW-1:0] romaddress,
  output logic [instW-1:0] inst,
  output logic             cpu_reset,
  output logic [addrW:0]   words_loaded,
  output logic             err
);

  // Handshake: a beat transfers on a rising clk edge where ld_valid and
  // ld_ready are both high; ld_data/ld_last are ignored on any other cycle.

  k2_state_e        state;
  k2_state_e        state_nx;
  logic [addrW-1:0] cnt;
  logic             accept;
  logic             wr_en;
  logic             final_beat;
  logic             enter_load;
  logic [instW-1:0] rdata;

  assign ld_ready   = (state == LOAD) || (state == CHECK);
  assign accept     = ld_valid & ld_ready;
  assign wr_en      = accept & (state == LOAD);
  assign final_beat = ld_last | (cnt == addrW'(depth - 1));
  assign enter_load = (state_nx == LOAD) && (state != LOAD);
  assign cpu_reset  = (state != RUN);
  assign inst       = (state == RUN) ? rdata : '0;

`ifdef K2_LOADER_CHECKSUM_EN
  logic [instW-1:0] sum;
  logic             sum_match;
  logic             err_q;

  assign sum_match = (ld_data == sum);
  assign err       = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_start) state_nx = LOAD;
      end
      LOAD: begin
        if (accept && final_beat) begin
`ifdef K2_LOADER_CHECKSUM_EN
          state_nx = CHECK;
`else
          state_nx = RUN;
`endif
        end
      end
`ifdef K2_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_nx = sum_match ? RUN : ERROR;
      end
      ERROR: begin
        if (load_start) state_nx = LOAD;
      end
`endif
      RUN: begin
        if (load_start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // cnt wraps back to zero on the last-slot beat, which also leaves LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      words_loaded <= '0;
    end else if (enter_load) begin
      cnt          <= '0;
      words_loaded <= '0;
    end else if (wr_en) begin
      cnt          <= cnt + addrW'(1);
      words_loaded <= words_loaded + (addrW + 1)'(1);
    end
  end

`ifdef K2_LOADER_CHECKSUM_EN
  // The checksum beat itself is compared, never summed or stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (enter_load) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (wr_en) begin
      sum <= sum + ld_data;
    end else if ((state == CHECK) && accept && !sum_match) begin
      err_q <= 1'b1;
    end
  end
`endif

  k2_inst_ram #(
    .instW(instW),
    .addrW(addrW),
    .depth(depth)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(cnt),
    .wdata(ld_data),
    .raddr(romaddress),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed bench for k2_program_loader; follows K2_LOADER_CHECKSUM_EN when defined.
module tb_k2_program_loader;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [9:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic [3:0] romaddress = '0;
  logic [9:0] inst;
  logic       cpu_reset;
  logic [4:0] words_loaded;
  logic       err;

  logic         chk_strobe = 1'b0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [9:0]   sum;
  logic [9:0]   last_cs;

  always #5 clk = ~clk;

  k2_program_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .romaddress  (romaddress),
    .inst        (inst),
    .cpu_reset   (cpu_reset),
    .words_loaded(words_loaded),
    .err         (err)
  );

  function automatic logic [W-1:0] pack(input logic c, input logic r, input logic e,
                                        input logic [4:0] w, input logic [9:0] i);
    return {c, r, e, w, i};
  endfunction

  // Monitor: pops one expectation whenever the driver marks a sample cycle.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] expv;
    string        nm;
    if (chk_strobe) begin
      act = pack(cpu_reset, ld_ready, err, words_loaded, inst);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: sample with no expected entry");
      end else begin
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL %s: got cpu_reset=%0b ld_ready=%0b err=%0b words_loaded=%0d inst=%h, expected cpu_reset=%0b ld_ready=%0b err=%0b words_loaded=%0d inst=%h",
                   nm, act[17], act[16], act[15], act[14:10], act[9:0],
                   expv[17], expv[16], expv[15], expv[14:10], expv[9:0]);
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic probe(input string nm, input logic [3:0] addr, input logic c,
                       input logic r, input logic e, input logic [4:0] w,
                       input logic [9:0] i);
    romaddress = addr;
    exp_q.push_back(pack(c, r, e, w, i));
    name_q.push_back(nm);
    chk_strobe = 1'b1;
    @(negedge clk);
    #1 chk_strobe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_probe(input string nm, input logic [3:0] addr,
                           input logic [4:0] w, input logic [9:0] i);
    probe(nm, addr, 1'b0, 1'b0, 1'b0, w, i);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [9:0] base, input logic [9:0] step,
                        input logic use_last);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + step * 10'(i);
      ld_last  = use_last && (i == n - 1);
      sum      = sum + ld_data;
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic finish_load(input logic [9:0] cs);
    last_cs = cs;
`ifdef K2_LOADER_CHECKSUM_EN
    ld_valid = 1'b1;
    ld_data  = cs;
    ld_last  = 1'b0;
    @(posedge clk);
    #1 ld_valid = 1'b0;
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    probe("reset_state", 4'd5, 1'b1, 1'b0, 1'b0, 5'd0, 10'h000);

    // Full back-to-back load of 16 words.
    pulse_start();
    probe("load_entry", 4'd0, 1'b1, 1'b1, 1'b0, 5'd0, 10'h000);
    stream(16, 10'h3A0, 10'd1, 1'b0);
    finish_load(sum);
    run_probe("full_addr5", 4'd5, 5'd16, 10'h3A5);
    run_probe("full_addr15", 4'd15, 5'd16, 10'h3AF);
    run_probe("full_addr0", 4'd0, 5'd16, 10'h3A0);

    // Stream activity while running must not touch the store.
    ld_valid = 1'b1;
    ld_data  = 10'h000;
    ld_last  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    run_probe("run_ignores_valid", 4'd3, 5'd16, 10'h3A3);

    // Gapped stream; idle cycles carry junk data, ld_last and a stray load_start.
    pulse_start();
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        ld_valid = 1'b1;
        ld_data  = 10'h150 + 10'(i / 2);
        ld_last  = 1'b0;
        sum      = sum + ld_data;
      end else begin
        ld_valid = 1'b0;
        ld_data  = 10'h3FF;
        ld_last  = 1'b1;
      end
      load_start = (i == 9);
      @(posedge clk);
      #1;
    end
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    load_start = 1'b0;
    finish_load(sum);
    run_probe("gap_addr0", 4'd0, 5'd16, 10'h150);
    run_probe("gap_addr7", 4'd7, 5'd16, 10'h157);
    run_probe("gap_addr15", 4'd15, 5'd16, 10'h15F);

    // Early end: preload, then overwrite only the first 4 words.
    pulse_start();
    stream(16, 10'h3A0, 10'd1, 1'b0);
    finish_load(sum);
    pulse_start();
    probe("reload_hold", 4'd2, 1'b1, 1'b1, 1'b0, 5'd0, 10'h000);
    stream(4, 10'h010, 10'd1, 1'b1);
    finish_load(sum);
    run_probe("early_addr2", 4'd2, 5'd4, 10'h012);
    run_probe("early_addr3", 4'd3, 5'd4, 10'h013);
    run_probe("early_addr4_kept", 4'd4, 5'd4, 10'h3A4);
    run_probe("early_addr9_kept", 4'd9, 5'd4, 10'h3A9);

    // Reset in the middle of a load, then a clean full load.
    pulse_start();
    stream(7, 10'h200, 10'd1, 1'b0);
    probe("mid_load_count", 4'd0, 1'b1, 1'b1, 1'b0, 5'd7, 10'h000);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    probe("mid_reset", 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 10'h000);
    pulse_start();
    stream(16, 10'h0C0, 10'd1, 1'b0);
    finish_load(sum);
    run_probe("fresh_addr0", 4'd0, 5'd16, 10'h0C0);
    run_probe("fresh_addr7", 4'd7, 5'd16, 10'h0C7);
    run_probe("fresh_addr15", 4'd15, 5'd16, 10'h0CF);

`ifdef K2_LOADER_CHECKSUM_EN
    // Sixteen words of 1 sum to 10'h010.
    pulse_start();
    stream(16, 10'h001, 10'd0, 1'b0);
    finish_load(10'h011);
    probe("cs_error", 4'd0, 1'b1, 1'b0, 1'b1, 5'd16, 10'h000);
    pulse_start();
    probe("cs_err_cleared", 4'd0, 1'b1, 1'b1, 1'b0, 5'd0, 10'h000);
    stream(16, 10'h001, 10'd0, 1'b0);
    finish_load(10'h010);
    run_probe("cs_run", 4'd4, 5'd16, 10'h001);
`endif

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
